// File: rtl/pulse_sched_pkg.sv
// Shared types and constants for the pulse_sched shared-pulse scheduler.
package pulse_sched_pkg;
  localparam int   LEN_W_DEF = 4;
  localparam logic REQ_A     = 1'b0;
  localparam logic REQ_B     = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/pulse_timer.sv
// Pulse length counter: load takes priority over decrement; flags the last high cycle.
module pulse_timer #(
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [LEN_W-1:0] val_i,
  output logic             is_one_o
);
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = val_i;
    else if (dec_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign is_one_o = (cnt_q == LEN_W'(1));
endmodule

// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one registered pulse line between requesters A and B.
// Optional: define PULSE_SCHED_BACK2BACK_EN to arbitrate the other requester straight out of GAP.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             req_a,
  input  logic [LEN_W-1:0] len_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [LEN_W-1:0] len_b,
  output logic             ack_b,
  output logic             out,
  output logic             busy,
  output logic             grant_b
);
  state_t           state_q, state_d;
  logic             out_q, out_d;
  logic             grant_q, grant_d;
  logic             arb, load, dec, is_one, win_b;
  logic [LEN_W-1:0] win_len;

  // With both requesting, the one not served last wins.
  assign win_b   = (req_a && req_b) ? ~grant_q : req_b;
  assign win_len = win_b ? len_b : len_a;

  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    grant_d = grant_q;
    arb     = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      IDLE:  arb = req_a | req_b;
      PULSE: begin
        dec = 1'b1;
        if (is_one) state_d = GAP;
        else        out_d   = 1'b1;
      end
      GAP: begin
        state_d = IDLE;
`ifdef PULSE_SCHED_BACK2BACK_EN
        // Only the requester not just served may chain; win_b then picks it.
        arb = (grant_q == REQ_B) ? req_a : req_b;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      grant_d = win_b;
      load    = 1'b1;
      if (win_len != '0) begin
        out_d   = 1'b1;
        state_d = PULSE;
      end else begin
        state_d = GAP;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
      grant_q <= REQ_B;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      grant_q <= grant_d;
    end
  end

  pulse_timer #(.LEN_W(LEN_W)) u_timer (
    .clock    (clock),
    .reset_   (reset_),
    .load_i   (load),
    .dec_i    (dec),
    .val_i    (win_len),
    .is_one_o (is_one)
  );

  assign out     = out_q;
  assign busy    = (state_q != IDLE);
  assign grant_b = grant_q;
  assign ack_a   = (state_q == GAP) && (grant_q == REQ_A);
  assign ack_b   = (state_q == GAP) && (grant_q == REQ_B);
endmodule

// File: tb/tb_pulse_sched.sv
// Randomized and directed bench for pulse_sched against a remaining-cycles reference model.
module tb_pulse_sched;
  localparam int LEN_W = 4;

  logic             clock = 1'b0;
  logic             reset_ = 1'b0;
  logic             req_a = 1'b0, req_b = 1'b0;
  logic [LEN_W-1:0] len_a = '0, len_b = '0;
  logic             ack_a, ack_b, out, busy, grant_b;

  pulse_sched #(.LEN_W(LEN_W)) dut (
    .clock   (clock),
    .reset_  (reset_),
    .req_a   (req_a),
    .len_a   (len_a),
    .ack_a   (ack_a),
    .req_b   (req_b),
    .len_b   (len_b),
    .ack_b   (ack_b),
    .out     (out),
    .busy    (busy),
    .grant_b (grant_b)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference: high cycles still to emit, a pending gap cycle, and the last owner.
  int   m_hi  = 0;
  bit   m_gap = 0;
  bit   m_gb  = 1;

  task automatic m_start(input bit w);
    int n;
    m_gb = w;
    n = w ? int'(len_b) : int'(len_a);
    if (n > 0) m_hi = n;
    else       m_gap = 1;
  endtask

  task automatic m_edge();
    if (!reset_) begin
      m_hi = 0; m_gap = 0; m_gb = 1;
    end else if (m_hi > 0) begin
      m_hi--;
      if (m_hi == 0) m_gap = 1;
    end else if (m_gap) begin
      m_gap = 0;
`ifdef PULSE_SCHED_BACK2BACK_EN
      if (m_gb ? req_a : req_b) m_start(!m_gb);
`endif
    end else if (req_a || req_b) begin
      m_start((req_a && req_b) ? !m_gb : req_b);
    end
  endtask

  // Counters accumulated by directed sections.
  int c_hi, c_acka, c_ackb, c_busy;

  // One clock: model follows the edge, outputs checked on the falling edge,
  // then requesters that saw their ack drop req.
  task automatic cycle();
    bit ea, eb;
    @(posedge clock);
    m_edge();
    @(negedge clock);
    ea = m_gap && !m_gb;
    eb = m_gap && m_gb;
    chk("out",     out,     32'(m_hi > 0));
    chk("ack_a",   ack_a,   32'(ea));
    chk("ack_b",   ack_b,   32'(eb));
    chk("busy",    busy,    32'((m_hi > 0) || m_gap));
    chk("grant_b", grant_b, 32'(m_gb));
    c_hi   += int'(out);
    c_acka += int'(ack_a);
    c_ackb += int'(ack_b);
    c_busy += int'(busy);
    if (ea) req_a = 1'b0;
    if (eb) req_b = 1'b0;
  endtask

  task automatic clr();
    c_hi = 0; c_acka = 0; c_ackb = 0; c_busy = 0;
  endtask

  task automatic do_reset();
    reset_ = 1'b0; req_a = 1'b0; req_b = 1'b0;
    cycle();
    reset_ = 1'b1;
  endtask

  logic [6:0] pat;

  initial begin
    do_reset();
    chk("rst_grant", grant_b, 1);
    chk("rst_busy",  busy,    0);

    // Single A request, len 3.
    clr(); req_a = 1; len_a = 3;
    repeat (8) cycle();
    chk("len3_hi", c_hi, 3); chk("len3_ack", c_acka, 1); chk("len3_busy", c_busy, 4);

    // Both pending after reset: A first, then B.
    do_reset(); clr();
    req_a = 1; len_a = 2; req_b = 1; len_b = 4;
    repeat (14) cycle();
    chk("ab_hi", c_hi, 6); chk("ab_acka", c_acka, 1); chk("ab_ackb", c_ackb, 1);
    chk("ab_grant", grant_b, 1);

    // Zero-length B request: gap and ack only.
    clr(); req_b = 1; len_b = 0;
    repeat (5) cycle();
    chk("len0_hi", c_hi, 0); chk("len0_ack", c_ackb, 1); chk("len0_busy", c_busy, 1);

    // Reset during the second high cycle of a len-5 pulse.
    do_reset(); clr(); req_a = 1; len_a = 5;
    cycle(); cycle();
    chk("mid_hi2", out, 1);
    do_reset();
    chk("mid_out", out, 0); chk("mid_busy", busy, 0); chk("mid_grant", grant_b, 1);
    chk("mid_ack", c_acka, 0);

    // Maximum length.
    clr(); req_a = 1; len_a = 15;
    repeat (20) cycle();
    chk("len15_hi", c_hi, 15); chk("len15_ack", c_acka, 1);

    // Back-to-back pattern, A and B both len 2.
    do_reset(); req_a = 1; len_a = 2; req_b = 1; len_b = 2;
    for (int i = 6; i >= 0; i--) begin
      cycle();
      pat[i] = out;
    end
`ifdef PULSE_SCHED_BACK2BACK_EN
    chk("b2b_pat", 32'(pat), 32'(7'b1101100));
`else
    chk("b2b_pat", 32'(pat), 32'(7'b1100110));
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      reset_ = ($urandom % 400 != 0);
      if (!req_a && ($urandom % 4 == 0)) begin
        req_a = 1;
        len_a = ($urandom % 6 == 0) ? 4'd0 : ($urandom % 5 == 0) ? 4'd15 : 4'($urandom_range(1, 6));
      end
      if (!req_b && ($urandom % 4 == 0)) begin
        req_b = 1;
        len_b = ($urandom % 6 == 0) ? 4'd0 : ($urandom % 5 == 0) ? 4'd15 : 4'($urandom_range(1, 6));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
